// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - shared widths, NOP encoding and loader state type for the fetch stage
package uc_pkg;
   localparam int PC_W    = 12;
   localparam int INSTR_W = 16;
   localparam int IMEM_AW = 8;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

   typedef enum logic [1:0] {
      BOOT_IDLE  = 2'd0,
      BOOT_COUNT = 2'd1,
      BOOT_HI    = 2'd2,
      BOOT_LO    = 2'd3
   } boot_state_t;
endpackage

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - instruction memory, one synchronous write port, one asynchronous read port
module instr_mem #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   // Contents survive reset so a program loaded once outlives a core reset.
   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, instruction fetch and bootstrap byte-stream loader
module fetch_unit
   import uc_pkg::*;
#(
   parameter int PC_W    = uc_pkg::PC_W,
   parameter int INSTR_W = uc_pkg::INSTR_W,
   parameter int IMEM_AW = uc_pkg::IMEM_AW
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic               pc_inc,
   input  logic               pc_load,
   input  logic [PC_W-1:0]    pc_next,
   input  logic               boot_start,
   input  logic               boot_valid,
   input  logic [7:0]         boot_byte,
   output logic               boot_ready,
   output logic               bootstrapping,
   output logic               boot_done,
   output logic [INSTR_W-1:0] instruction,
   output logic [PC_W-1:0]    pc
);
   boot_state_t        state;
   logic [IMEM_AW-1:0] waddr;
   logic [8:0]         remaining;
   logic [7:0]         hi;
   logic               accept;
   logic               mem_we;
   logic [IMEM_AW-1:0] fa_idx;
   logic [INSTR_W-1:0] rdata;

   assign boot_ready    = (state != BOOT_IDLE);
   assign bootstrapping = (state != BOOT_IDLE);
   assign accept        = boot_valid && boot_ready;
   assign mem_we        = accept && (state == BOOT_LO);

   // Jump target bypasses the PC register so the target word is fetched in the load cycle.
   assign fa_idx      = pc_load ? pc_next[IMEM_AW-1:0] : pc[IMEM_AW-1:0];
   assign instruction = bootstrapping ? NOP_INSTR : rdata;

   instr_mem #(
      .AW (IMEM_AW),
      .DW (INSTR_W)
   ) u_imem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (waddr),
      .wdata ({hi, boot_byte}),
      .raddr (fa_idx),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state     <= BOOT_IDLE;
         pc        <= '0;
         boot_done <= 1'b0;
         waddr     <= '0;
         remaining <= '0;
         hi        <= '0;
      end else begin
         boot_done <= 1'b0;

         case (state)
            BOOT_IDLE: begin
               if (boot_start) begin
                  state <= BOOT_COUNT;
                  waddr <= '0;
               end
            end
            BOOT_COUNT: begin
               if (accept) begin
                  remaining <= (boot_byte == 8'd0) ? 9'd256 : {1'b0, boot_byte};
                  state     <= BOOT_HI;
               end
            end
            BOOT_HI: begin
               if (accept) begin
                  hi    <= boot_byte;
                  state <= BOOT_LO;
               end
            end
            BOOT_LO: begin
               if (accept) begin
                  waddr     <= waddr + IMEM_AW'(1);
                  remaining <= remaining - 9'd1;
                  if (remaining == 9'd1) begin
                     boot_done <= 1'b1;
                     state     <= BOOT_IDLE;
                  end else begin
                     state <= BOOT_HI;
                  end
               end
            end
            default: state <= BOOT_IDLE;
         endcase

         // PC is pinned to 0 for the whole load, including the start cycle.
         if (bootstrapping || (boot_start && (state == BOOT_IDLE))) begin
            pc <= '0;
         end else if (pc_load && pc_inc) begin
            pc <= pc_next + PC_W'(1);
         end else if (pc_load) begin
            pc <= pc_next;
         end else if (pc_inc) begin
            pc <= pc + PC_W'(1);
         end
      end
   end
endmodule
